code_entry_ctrl: RTL and testbench

Sequencing controller for the shared 4-bit decade (0–9) counter in the binary encryption game. It clears the counter, gates its count enable from the player's spin button, and locks the counter value on each enter press. Locked values fill a DIGITS-long BCD code register, and `done` pulses once the code is complete. It sits between the debounced player buttons and the counter instance; its `code` output feeds the encryption/compare stage.

---
 rtl/code_entry_ctrl.sv | 98 +++++++++
 tb/tb_code_entry_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_ctrl.sv
// Code entry sequencer for the shared decade counter: clears it, gates its enable from
// the spin button, and latches one BCD digit per enter press into the code register.
module code_entry_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  btn,
    input  logic                  enter,
    input  logic                  cancel,
    input  logic [3:0]            cnt_val,
    output logic                  cnt_en,
    output logic                  cnt_rst_n,
    output logic [4*DIGITS-1:0]   code,
    output logic [2:0]            digit_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_HOLD    = 3'd2,
        S_SPIN    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] code_q, code_d;
    logic [2:0]          idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    code_d  = '0;
                    idx_d   = '0;
                end
            end
            S_CLEAR: state_d = S_HOLD;
            S_HOLD, S_SPIN: begin
                // cancel outranks enter, which outranks the spin button
                if (cancel) begin
                    state_d = S_IDLE;
                    code_d  = '0;
                    idx_d   = '0;
                end else if (enter) begin
                    state_d = S_CAPTURE;
                end else if (state_q == S_HOLD && btn) begin
                    state_d = S_SPIN;
                end else if (state_q == S_SPIN && !btn) begin
                    state_d = S_HOLD;
                end
            end
            S_CAPTURE: begin
                code_d[4*int'(idx_q) +: 4] = cnt_val;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_CLEAR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_en    = (state_q == S_SPIN) & btn & ~enter & ~cancel;
        cnt_rst_n = rst & (state_q != S_CLEAR);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        code      = code_q;
        digit_idx = idx_q;
    end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl driving a behavioural decade counter from the
// controller's enable and clear outputs.
module tb_code_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, btn, enter, cancel;
    logic [3:0]  cnt;
    logic        cnt_en, cnt_rst_n, busy, done;
    logic [15:0] code;
    logic [2:0]  digit_idx;

    int checks = 0;
    int errors = 0;

    code_entry_ctrl #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn), .enter(enter),
        .cancel(cancel), .cnt_val(cnt), .cnt_en(cnt_en), .cnt_rst_n(cnt_rst_n),
        .code(code), .digit_idx(digit_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Decade counter model: synchronous active-low clear, wraps 9 -> 0
    always @(posedge clk) begin
        if (!cnt_rst_n)   cnt <= 4'd0;
        else if (cnt_en)  cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_entry();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // Spin n enabled cycles (if any), then press enter; returns after CAPTURE's edge
    task automatic enter_digit(input int n);
        if (n > 0) begin
            btn = 1'b1;
            tick();
            repeat (n) tick();
            btn = 1'b0;
        end
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; btn = 1'b0; enter = 1'b0; cancel = 1'b0;
        cnt = 4'd7;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt_rst_n", cnt_rst_n, 0);
        check("rst_code", code, 0);
        check("rst_idx", digit_idx, 0);
        check("rst_cnt", cnt, 0);
        rst = 1'b1;
        #1;
        check("rst_release_cnt_rst_n", cnt_rst_n, 1);

        // Single digit with wrap: 12 enabled cycles -> 2
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clear_cnt_rst_n", cnt_rst_n, 0);
        check("clear_busy", busy, 1);
        tick();
        check("hold_cnt", cnt, 0);
        check("hold_cnt_en", cnt_en, 0);
        btn = 1'b1;
        tick();
        check("spin_cnt_en", cnt_en, 1);
        repeat (12) tick();
        check("wrap_cnt", cnt, 2);
        enter = 1'b1;
        #1;
        check("enter_btn_cnt_en", cnt_en, 0);
        tick();
        enter = 1'b0; btn = 1'b0;
        check("capture_frozen_cnt", cnt, 2);
        tick();
        check("wrap_code", code, 16'h0002);
        check("wrap_idx", digit_idx, 1);
        tick();
        check("next_hold_cnt", cnt, 0);
        check("no_done_single", done, 0);

        // Cancel together with enter and btn in SPIN
        btn = 1'b1;
        tick();
        enter = 1'b1; cancel = 1'b1;
        #1;
        check("cancel_cnt_en", cnt_en, 0);
        tick();
        enter = 1'b0; cancel = 1'b0; btn = 1'b0;
        check("cancel_busy", busy, 0);
        check("cancel_code", code, 0);
        check("cancel_idx", digit_idx, 0);

        // Full code 3,0,9,5
        begin_entry();
        enter_digit(3);
        tick();
        enter_digit(0);
        tick();
        enter_digit(9);
        tick();
        btn = 1'b1;
        tick();
        repeat (5) tick();
        btn = 1'b0;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check("last_capture_done", done, 0);
        tick();
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("full_code", code, 16'h5903);
        tick();
        check("done_clear", done, 0);
        check("after_done_busy", busy, 0);
        check("after_done_idx", digit_idx, 3);

        // enter in IDLE is ignored
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check("idle_enter_busy", busy, 0);
        check("idle_enter_code", code, 16'h5903);
        tick();
        check("idle_enter_done", done, 0);

        // Zero spin, then pause/resume 4 + 3 = 7; start during SPIN ignored
        begin_entry();
        enter_digit(0);
        check("zero_code", code, 16'h0000);
        check("zero_idx", digit_idx, 1);
        tick();
        btn = 1'b1;
        tick();
        repeat (4) tick();
        btn = 1'b0;
        tick();
        check("pause_cnt", cnt, 4);
        check("pause_cnt_en", cnt_en, 0);
        btn = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_spin_busy", busy, 1);
        check("start_in_spin_cnt_en", cnt_en, 1);
        repeat (2) tick();
        check("resume_cnt", cnt, 7);
        btn = 1'b0;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        check("resume_code", code, 16'h0070);
        check("resume_idx", digit_idx, 2);

        // Reset mid-SPIN with partial code
        tick();
        btn = 1'b1;
        tick();
        repeat (2) tick();
        check("pre_rst_cnt", cnt, 2);
        rst = 1'b0;
        tick();
        tick();
        check("midrst_cnt_rst_n", cnt_rst_n, 0);
        check("midrst_cnt_en", cnt_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_code", code, 0);
        check("midrst_idx", digit_idx, 0);
        check("midrst_cnt", cnt, 0);
        rst = 1'b1;
        btn = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
